// File: rtl/fns_checker_pkg.sv
// Shared types and sizes for the function-sweep checker.
package fns_checker_pkg;

  localparam int unsigned VEC_W     = 4;
  localparam int unsigned VEC_COUNT = 16;
  localparam int unsigned ERR_W     = 7;
  localparam int unsigned N_OUT     = 6;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Expected response words for one stimulus vector.
  typedef struct packed {
    logic [VEC_W-1:0] o6;
    logic [VEC_W-1:0] o5;
    logic [VEC_W-1:0] o4;
    logic [VEC_W-1:0] o3;
    logic [VEC_W-1:0] o2;
    logic [VEC_W-1:0] o1;
  } exp_t;

  // Number of set bits in a per-vector mismatch mask.
  function automatic logic [2:0] popcount6(input logic [N_OUT-1:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      c = c + 3'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/fns_golden.sv
// Combinational reference: the six expected response words for vector a.
module fns_golden
  import fns_checker_pkg::*;
(
  input  logic [VEC_W-1:0] a,
  output exp_t             exp_o
);

  assign exp_o.o1 = {a[2], a[1], a[0], a[0]};
  assign exp_o.o2 = {a[1:0], a[1:0]};
  assign exp_o.o3 = a & {VEC_W{a[3]}};
  assign exp_o.o4 = a;
  assign exp_o.o5 = a;
  assign exp_o.o6 = {a[2], 1'b0, a[2], 1'b0};

endmodule

// File: rtl/fns_checker.sv
// Sweeps a over 0..15, compares o1..o6 against the golden model and
// reports error count plus the first failing vector and its mask.
module fns_checker
  import fns_checker_pkg::*;
#(
  parameter int unsigned SETTLE       = 1,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] o1,
  input  logic [VEC_W-1:0] o2,
  input  logic [VEC_W-1:0] o3,
  input  logic [VEC_W-1:0] o4,
  input  logic [VEC_W-1:0] o5,
  input  logic [VEC_W-1:0] o6,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_vec,
  output logic [N_OUT-1:0] fail_mask
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE == 0 ? 0 : SETTLE - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(VEC_COUNT - 1);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] fvec_q, fvec_d;
  logic [N_OUT-1:0] fmask_q, fmask_d;

  exp_t             exp_c;
  logic [N_OUT-1:0] mask_c;

  fns_golden u_golden (
    .a     (a_q),
    .exp_o (exp_c)
  );

  // Per-output mismatch flags for the vector currently on a.
  always_comb begin
    mask_c    = '0;
    mask_c[0] = (o1 != exp_c.o1);
    mask_c[1] = (o2 != exp_c.o2);
    mask_c[2] = (o3 != exp_c.o3);
    mask_c[3] = (o4 != exp_c.o4);
    mask_c[4] = (o5 != exp_c.o5);
    mask_c[5] = (o6 != exp_c.o6);
  end

  // Sweep sequencing, scoring and next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fmask_d = fmask_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          a_d     = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          err_d   = '0;
          fvec_d  = '0;
          fmask_d = '0;
        end
      end
      ST_DRIVE: begin
        cnt_d   = '0;
        state_d = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        err_d = err_q + ERR_W'(popcount6(mask_c));
        // fmask_q is nonzero exactly once a failure has been recorded.
        if ((mask_c != '0) && (fmask_q == '0)) begin
          fvec_d  = a_q;
          fmask_d = mask_c;
        end
        if ((a_q == LAST_VEC) || (STOP_ON_FAIL && (mask_c != '0))) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_DRIVE;
          a_d     = a_q + VEC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      fmask_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fmask_q <= fmask_d;
    end
  end

  assign a         = a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fvec_q;
  assign fail_mask = fmask_q;

endmodule

// File: tb/tb_fns_checker.sv
// Bench for fns_checker: three instances (SETTLE=1, SETTLE=1 stop-on-fail,
// SETTLE=0) each driven by a behavioural DUT model with selectable faults.
module tb_fns_checker;

  localparam int NI    = 3;
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_w [NI];
  logic [3:0]  a_w     [NI];
  logic [23:0] resp_w  [NI];
  logic        busy_w  [NI];
  logic        done_w  [NI];
  logic        pass_w  [NI];
  logic [6:0]  err_w   [NI];
  logic [3:0]  fv_w    [NI];
  logic [5:0]  fm_w    [NI];
  int          fault_w [NI];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         inst;
    int         fault;
    int         glitch;
    int         cycles;
    logic [6:0] err;
    logic [3:0] fvec;
    logic [5:0] fmask;
    logic       pass;
  } vec_t;

  typedef struct {
    int         cycles;
    logic [6:0] err;
    logic [3:0] fvec;
    logic [5:0] fmask;
    logic       pass;
  } sb_t;

  sb_t sb_q[$];

  always #5 clk = ~clk;

  // Ideal function-under-test, packed {o6,o5,o4,o3,o2,o1}.
  function automatic logic [23:0] golden(input logic [3:0] v);
    logic [3:0] e1, e2, e3, e4, e5, e6;
    e1 = {v[2:0], v[0]};
    e2 = {2{v[1:0]}};
    e3 = v[3] ? v : 4'b0000;
    e4 = v;
    e5 = v;
    e6 = {v[2], 1'b0, v[2], 1'b0};
    return {e6, e5, e4, e3, e2, e1};
  endfunction

  // Faulty variants of the function-under-test.
  function automatic logic [23:0] respond(input logic [3:0] v, input int f);
    logic [23:0] r;
    r = golden(v);
    case (f)
      1: r[12] = 1'b0;                 // o4 bit0 stuck at 0
      2: r[23:20] = 4'b0000;           // o6 forced to 0
      3: r = ~r;                       // everything inverted
      4: r[7] = 1'b1;                  // o2 bit3 stuck at 1
      5: if (v == 4'd9) r[0] = ~r[0];  // o1 bit0 wrong on vector 9 only
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NI; i++) resp_w[i] = respond(a_w[i], fault_w[i]);
  end

  fns_checker #(.SETTLE(1), .STOP_ON_FAIL(1'b0)) u_s1 (
    .clk(clk), .rst(rst), .start(start_w[0]), .a(a_w[0]),
    .o1(resp_w[0][3:0]), .o2(resp_w[0][7:4]), .o3(resp_w[0][11:8]),
    .o4(resp_w[0][15:12]), .o5(resp_w[0][19:16]), .o6(resp_w[0][23:20]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .fail_vec(fv_w[0]), .fail_mask(fm_w[0])
  );

  fns_checker #(.SETTLE(1), .STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst(rst), .start(start_w[1]), .a(a_w[1]),
    .o1(resp_w[1][3:0]), .o2(resp_w[1][7:4]), .o3(resp_w[1][11:8]),
    .o4(resp_w[1][15:12]), .o5(resp_w[1][19:16]), .o6(resp_w[1][23:20]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .fail_vec(fv_w[1]), .fail_mask(fm_w[1])
  );

  fns_checker #(.SETTLE(0), .STOP_ON_FAIL(1'b0)) u_s0 (
    .clk(clk), .rst(rst), .start(start_w[2]), .a(a_w[2]),
    .o1(resp_w[2][3:0]), .o2(resp_w[2][7:4]), .o3(resp_w[2][11:8]),
    .o4(resp_w[2][15:12]), .o5(resp_w[2][19:16]), .o6(resp_w[2][23:20]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_count(err_w[2]), .fail_vec(fv_w[2]), .fail_mask(fm_w[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  // All report outputs of one instance, packed {a,busy,done,pass,err,fvec,fmask}.
  function automatic logic [31:0] snap(input int i);
    return 32'({a_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i], fv_w[i], fm_w[i]});
  endfunction

  // One sweep: push expectation, pulse start, follow the sweep, pop and compare.
  task automatic run(input vec_t v, input string tag);
    sb_t e;
    int  i, s, cyc;
    bit  seq_ok;
    i = v.inst;
    s = settle_of(i);
    e.cycles = v.cycles; e.err = v.err; e.fvec = v.fvec;
    e.fmask = v.fmask;   e.pass = v.pass;
    sb_q.push_back(e);
    fault_w[i] = v.fault;

    @(negedge clk);
    start_w[i] = 1'b1;
    @(posedge clk);
    #1;
    start_w[i] = 1'b0;
    check({tag, "_start_clear"}, 32'({busy_w[i], done_w[i], pass_w[i], err_w[i], fv_w[i], fm_w[i]}),
          32'({1'b1, 1'b0, 1'b0, 7'd0, 4'd0, 6'd0}));

    seq_ok = 1'b1;
    cyc    = 0;
    while (done_w[i] !== 1'b1 && cyc < LIMIT) begin
      if (busy_w[i] !== 1'b1 || a_w[i] !== 4'(cyc / (s + 2))) seq_ok = 1'b0;
      start_w[i] = (v.glitch >= 0 && cyc == v.glitch);
      @(posedge clk);
      #1;
      cyc++;
    end
    start_w[i] = 1'b0;

    e = sb_q.pop_front();
    check({tag, "_done_cycle"}, 32'(cyc), 32'(e.cycles));
    check({tag, "_a_seq_busy"}, 32'(seq_ok), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy_w[i]), 32'd0);
    check({tag, "_err_count"}, 32'(err_w[i]), 32'(e.err));
    check({tag, "_fail_vec"}, 32'(fv_w[i]), 32'(e.fvec));
    check({tag, "_fail_mask"}, 32'(fm_w[i]), 32'(e.fmask));
    check({tag, "_pass"}, 32'(pass_w[i]), 32'(e.pass));
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{0, 0, -1, 48, 7'd0,  4'd0, 6'b000000, 1'b1};
    tbl[1] = '{0, 1, -1, 48, 7'd8,  4'd1, 6'b001000, 1'b0};
    tbl[2] = '{1, 2, -1, 15, 7'd1,  4'd4, 6'b100000, 1'b0};
    tbl[3] = '{2, 3, -1, 32, 7'd96, 4'd0, 6'b111111, 1'b0};
    tbl[4] = '{2, 0, -1, 32, 7'd0,  4'd0, 6'b000000, 1'b1};
    tbl[5] = '{0, 0, 10, 48, 7'd0,  4'd0, 6'b000000, 1'b1};
    tbl[6] = '{0, 0, -1, 48, 7'd0,  4'd0, 6'b000000, 1'b1};
    tbl[7] = '{0, 4, -1, 48, 7'd8,  4'd0, 6'b000010, 1'b0};
    tbl[8] = '{1, 5, -1, 30, 7'd1,  4'd9, 6'b000001, 1'b0};

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_w[i] = 1'b0;
      fault_w[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check($sformatf("reset_state_%0d", i), snap(i), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) run(tbl[k], $sformatf("vec%0d", k));

    // Abort mid-sweep with reset; outputs must clear without a clock edge.
    fault_w[0] = 0;
    @(negedge clk);
    start_w[0] = 1'b1;
    @(posedge clk);
    #1;
    start_w[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("busy_before_rst", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_clear", snap(0), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_clear", snap(0), 32'd0);
    rst = 1'b0;
    run(tbl[0], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fns_checker.md
FNS_CHECKER -- requirements
Module: fns_checker

Interface
REQ-001 Parameter SETTLE, default 1: wait cycles between driving a vector and sampling the DUT outputs (legal 0..15).
REQ-002 Parameter STOP_ON_FAIL, default 0: when 1, the sweep ends at the first failing vector.
REQ-003 clk  input  1  sole clock; every flop is rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a sweep.
REQ-006 a  output  4  stimulus vector to the function-test DUT.
REQ-007 o1..o6  input  4 each  DUT responses.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high from sweep end until the next accepted start.
REQ-010 pass  output  1  valid while done; 1 when err_count==0.
REQ-011 err_count  output  7  number of mismatching 4-bit output words.
REQ-012 fail_vec  output  4  a value of the first failing vector.
REQ-013 fail_mask  output  6  mismatch mask of the first failing vector; bit k-1 corresponds to o<k>.

Function
REQ-014 The sweep SHALL step a from 0 to 15 in ascending order, one vector at a time.
REQ-015 Expected o1 SHALL be {a[2], a[1], a[0], a[0]}.
REQ-016 Expected o2 SHALL be {a[1:0], a[1:0]}.
REQ-017 Expected o3 SHALL have bit i equal to a[i] & a[3].
REQ-018 Expected o4 and expected o5 SHALL each equal a.
REQ-019 Expected o6 SHALL be {a[2], 1'b0, a[2], 1'b0}.
REQ-020 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-021 IDLE->DRIVE on start; DRIVE->SETTLE; SETTLE->CHECK once SETTLE cycles have elapsed (immediately if SETTLE==0).
REQ-022 From CHECK, the FSM SHALL go to DONE after vector 15 (or on a failure with STOP_ON_FAIL=1), else to DRIVE with a incremented.
REQ-023 Each vector SHALL cost exactly SETTLE+2 cycles, and the full sweep 16*(SETTLE+2) cycles from start to done rising.
REQ-024 Comparison SHALL occur only in CHECK, using o1..o6 as sampled that cycle.
REQ-025 err_count SHALL add the popcount of the vector's 6-bit mismatch mask (maximum 96, no wrap).
REQ-026 fail_vec and fail_mask SHALL be captured only on the first vector with a nonzero mask and held to sweep end; they SHALL be 0 if no vector fails.
REQ-027 start while busy SHALL be ignored.
REQ-028 start in DONE SHALL clear done, err_count, fail_vec and fail_mask and restart at a=0 on the next cycle.
REQ-029 a SHALL hold its value through DRIVE, SETTLE and CHECK of each vector.
REQ-030 busy SHALL equal (state is not IDLE and not DONE); done SHALL equal (state==DONE).

Reset
REQ-031 rst SHALL force IDLE and zero a, busy, done, pass, err_count, fail_vec, fail_mask and the settle counter, with no clock required.
REQ-032 rst asserted mid-sweep SHALL abort the sweep with no report retained.
REQ-033 The first start after rst deasserts SHALL be honoured on the first clock edge.

Structure
REQ-034 Package fns_checker_pkg SHALL hold the state enum, the vector count (16) and the err_count width (7).
REQ-035 Expected values SHALL come from one combinational sub-module, fns_golden (a in; six 4-bit expected words out), instantiated once.
REQ-036 The settle counter SHALL be 4 bits, sized for the legal SETTLE range.

Verification
REQ-037 Ideal DUT model, SETTLE=1, start pulse -> done at cycle 48; pass=1, err_count=0, fail_mask=0.
REQ-038 Model with o4 bit0 stuck at 0 -> err_count=8, fail_vec=1, fail_mask=6'b001000.
REQ-039 Model with o6 forced to 0, STOP_ON_FAIL=1 -> sweep stops at a=4; fail_vec=4, fail_mask=6'b100000, err_count=1.
REQ-040 SETTLE=0 with all outputs inverted -> done at cycle 32; err_count=96, fail_vec=0, fail_mask=6'b111111.
REQ-041 rst asserted at cycle 20 -> every output 0 immediately; a new start then gives a clean 48-cycle pass.
REQ-042 start pulsed at cycle 10 of a sweep -> ignored, done still at cycle 48; a second start in DONE -> done drops and the sweep repeats.
